// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared types and constants for the pipeline hazard sequencer:
//                FSM state encoding, stall/flush control bundle, x0 index.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // Legacy-compatible state encodings, reused as the enum values
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MC_WAIT = 1'b1;

    typedef enum logic [0:0] {
        RUN     = ST_RUN,
        MC_WAIT = ST_MC_WAIT
    } hz_state_e;

    // pc_flush marks a cycle in which the PC is redirected (trap or taken
    // branch); it has no port of its own but drives the flush-event counter.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic mem_wb_stall;
        logic pc_flush;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } hz_ctrl_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Flags an ID-stage instruction that reads the destination of
//                a load currently in EX (x0 never creates a dependency).
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import core_pkg::*;
(
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_rs1_used,
    input  logic       i_id_rs2_used,
    input  logic [4:0] i_ex_rd_addr,
    input  logic       i_ex_mem_read,
    input  logic       i_ex_reg_write,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit  = i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr);
    assign o_load_use = i_ex_mem_read & i_ex_reg_write &
                        (i_ex_rd_addr != REG_X0) & (w_rs1_hit | w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Prioritises traps, data-memory waits, multi-cycle EX ops,
//                branch redirects and load-use hazards; includes a
//                multi-cycle watchdog and saturating performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter int MC_MAX_CYCLES = 64
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             ex_mc_start,
    input  logic             ex_mc_done,
    input  logic             ex_redirect,
    input  logic             mem_req_valid,
    input  logic             mem_ready,
    input  logic             trap,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_stall_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_stall_o,
    output logic             mem_wb_flush_o,
    output logic             mc_busy_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o
);

    localparam int MC_CNT_W = $clog2(MC_MAX_CYCLES + 1);

    localparam logic [MC_CNT_W-1:0] c_mc_max  = MC_CNT_W'(MC_MAX_CYCLES);
    localparam logic [MC_CNT_W-1:0] c_mc_pre  = MC_CNT_W'(MC_MAX_CYCLES - 1);
    localparam logic [MC_CNT_W-1:0] c_mc_one  = MC_CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0]    c_cnt_max = '1;

    hz_state_e           r_state;
    hz_state_e           w_state_nxt;
    hz_ctrl_t            w_ctrl;
    logic                w_load_use;
    logic                w_mem_hold;
    logic                w_mc_hold;
    logic [MC_CNT_W-1:0] r_mc_cnt;
    logic                r_mc_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    load_use_detect u_load_use_detect (
        .i_id_rs1_addr  (id_rs1_addr),
        .i_id_rs2_addr  (id_rs2_addr),
        .i_id_rs1_used  (id_rs1_used),
        .i_id_rs2_used  (id_rs2_used),
        .i_ex_rd_addr   (ex_rd_addr),
        .i_ex_mem_read  (ex_mem_read),
        .i_ex_reg_write (ex_reg_write),
        .o_load_use     (w_load_use)
    );

    assign w_mem_hold = mem_req_valid & ~mem_ready;
    // The MC hold already applies in the start cycle, before the FSM moves.
    assign w_mc_hold  = ((r_state == MC_WAIT) | ex_mc_start) & ~ex_mc_done;

    // Strict-priority stall/flush selection; a lower rule never overrides a higher one
    always_comb begin
        w_ctrl = '0;
        if (trap) begin
            w_ctrl.pc_flush     = 1'b1;
            w_ctrl.if_id_flush  = 1'b1;
            w_ctrl.id_ex_flush  = 1'b1;
            w_ctrl.ex_mem_flush = 1'b1;
            w_ctrl.mem_wb_flush = 1'b1;
        end else if (w_mem_hold) begin
            w_ctrl.pc_stall     = 1'b1;
            w_ctrl.if_id_stall  = 1'b1;
            w_ctrl.id_ex_stall  = 1'b1;
            w_ctrl.ex_mem_stall = 1'b1;
            w_ctrl.mem_wb_flush = 1'b1;
        end else if (w_mc_hold) begin
            w_ctrl.pc_stall     = 1'b1;
            w_ctrl.if_id_stall  = 1'b1;
            w_ctrl.id_ex_stall  = 1'b1;
            w_ctrl.ex_mem_flush = 1'b1;
        end else if (ex_redirect) begin
            w_ctrl.pc_flush     = 1'b1;
            w_ctrl.if_id_flush  = 1'b1;
            w_ctrl.id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
            w_ctrl.pc_stall     = 1'b1;
            w_ctrl.if_id_stall  = 1'b1;
            w_ctrl.id_ex_flush  = 1'b1;
        end
    end

    // Next-state logic: a start completing in the same cycle never leaves RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (ex_mc_start & ~ex_mc_done & ~trap) begin
                    w_state_nxt = MC_WAIT;
                end
            end
            MC_WAIT: begin
                if ((ex_mc_done & ~w_mem_hold) | trap) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // FSM state and watchdog; the pulse fires once when the count saturates
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_mc_cnt     <= '0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == RUN) begin
                r_mc_cnt <= '0;
            end else if ((r_state == MC_WAIT) && (r_mc_cnt != c_mc_max)) begin
                r_mc_cnt <= r_mc_cnt + c_mc_one;
            end
            r_mc_timeout <= (r_state == MC_WAIT) && (w_state_nxt == MC_WAIT) &&
                            (r_mc_cnt == c_mc_pre);
        end
    end

    // Saturating performance counters for stalled cycles and redirect events
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_ctrl.pc_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (w_ctrl.pc_flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

    assign pc_stall_o     = w_ctrl.pc_stall;
    assign if_id_stall_o  = w_ctrl.if_id_stall;
    assign if_id_flush_o  = w_ctrl.if_id_flush;
    assign id_ex_stall_o  = w_ctrl.id_ex_stall;
    assign id_ex_flush_o  = w_ctrl.id_ex_flush;
    assign ex_mem_stall_o = w_ctrl.ex_mem_stall;
    assign ex_mem_flush_o = w_ctrl.ex_mem_flush;
    assign mem_wb_stall_o = w_ctrl.mem_wb_stall;
    assign mem_wb_flush_o = w_ctrl.mem_wb_flush;
    assign mc_busy_o      = (r_state == MC_WAIT);
    assign mc_timeout_o   = r_mc_timeout;
    assign stall_cycles_o = r_stall_cnt;
    assign flush_events_o = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench: directed scenarios plus randomized
//                traffic compared against a behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 6;
    localparam int MC_MAX  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Rule outputs, ordered {pc_st, ifid_st, ifid_fl, idex_st, idex_fl,
    //                        exmem_st, exmem_fl, memwb_st, memwb_fl}
    localparam logic [8:0] V_TRAP = 9'b001010101;
    localparam logic [8:0] V_MEM  = 9'b110101001;
    localparam logic [8:0] V_MC   = 9'b110100100;
    localparam logic [8:0] V_RED  = 9'b001010000;
    localparam logic [8:0] V_LU   = 9'b110010000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic             id_rs1_used, id_rs2_used, ex_mem_read, ex_reg_write;
    logic             ex_mc_start, ex_mc_done, ex_redirect;
    logic             mem_req_valid, mem_ready, trap;
    logic             pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
    logic             id_ex_flush_o, ex_mem_stall_o, ex_mem_flush_o;
    logic             mem_wb_stall_o, mem_wb_flush_o, mc_busy_o, mc_timeout_o;
    logic [CNT_W-1:0] stall_cycles_o, flush_events_o;
    logic [8:0]       w_vec;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MC_MAX_CYCLES(MC_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .ex_redirect(ex_redirect),
        .mem_req_valid(mem_req_valid), .mem_ready(mem_ready), .trap(trap),
        .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o), .if_id_flush_o(if_id_flush_o),
        .id_ex_stall_o(id_ex_stall_o), .id_ex_flush_o(id_ex_flush_o),
        .ex_mem_stall_o(ex_mem_stall_o), .ex_mem_flush_o(ex_mem_flush_o),
        .mem_wb_stall_o(mem_wb_stall_o), .mem_wb_flush_o(mem_wb_flush_o),
        .mc_busy_o(mc_busy_o), .mc_timeout_o(mc_timeout_o),
        .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o)
    );

    assign w_vec = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o,
                    ex_mem_stall_o, ex_mem_flush_o, mem_wb_stall_o, mem_wb_flush_o};

    always #5 clk = ~clk;

    // Reference model state
    bit m_mc;      // a multi-cycle op is being waited on
    int m_run;     // consecutive waiting cycles, including the current one
    int m_stall;
    int m_flush;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit reads_reg(input logic [4:0] r);
        return (id_rs1_used && id_rs1_addr == r) || (id_rs2_used && id_rs2_addr == r);
    endfunction

    function automatic logic [8:0] exp_vec();
        bit lu, mh, mch;
        lu  = ex_mem_read && ex_reg_write && ex_rd_addr != 5'd0 && reads_reg(ex_rd_addr);
        mh  = mem_req_valid && !mem_ready;
        mch = (m_mc || ex_mc_start) && !ex_mc_done;
        if (trap)        return V_TRAP;
        if (mh)          return V_MEM;
        if (mch)         return V_MC;
        if (ex_redirect) return V_RED;
        if (lu)          return V_LU;
        return 9'd0;
    endfunction

    // Check all outputs at the negedge, then advance the model at the posedge
    task automatic tick();
        logic [8:0] ev;
        bit mh, mch, nxt;
        @(negedge clk);
        ev = exp_vec();
        chk_eq("ctrl", 32'(w_vec), 32'(ev));
        chk_eq("mc_busy", 32'(mc_busy_o), 32'(m_mc));
        chk_eq("mc_timeout", 32'(mc_timeout_o), 32'(m_mc && m_run == MC_MAX + 1));
        chk_eq("stall_cycles", 32'(stall_cycles_o), 32'(m_stall));
        chk_eq("flush_events", 32'(flush_events_o), 32'(m_flush));
        @(posedge clk);
        if (!rst_n) begin
            m_mc = 0; m_run = 0; m_stall = 0; m_flush = 0;
        end else begin
            mh  = mem_req_valid && !mem_ready;
            mch = (m_mc || ex_mc_start) && !ex_mc_done;
            if (ev[8] && m_stall < CNT_MAX) m_stall++;
            if ((trap || (ex_redirect && !mh && !mch)) && m_flush < CNT_MAX) m_flush++;
            nxt   = m_mc ? !((ex_mc_done && !mh) || trap) : (ex_mc_start && !ex_mc_done && !trap);
            m_run = nxt ? m_run + 1 : 0;
            m_mc  = nxt;
        end
        #1;
    endtask

    task automatic set_idle();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_rs1_used = 0; id_rs2_used = 0; ex_mem_read = 0; ex_reg_write = 0;
        ex_mc_start = 0; ex_mc_done = 0; ex_redirect = 0;
        mem_req_valid = 0; mem_ready = 0; trap = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; set_idle();
        tick(); tick();
        rst_n = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt_a, cnt_b;
        rst_n = 0; set_idle();
        m_mc = 0; m_run = 0; m_stall = 0; m_flush = 0;
        @(posedge clk); #1;
        do_reset();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 5'd5;
        id_rs1_used = 1; id_rs1_addr = 5'd5; id_rs2_used = 1; id_rs2_addr = 5'd1;
        #1 chk_eq("lu_vec", 32'(w_vec), 32'(V_LU));
        tick();
        set_idle(); tick();
        // Same shape against x0: no hazard
        ex_mem_read = 1; ex_reg_write = 1; ex_rd_addr = 5'd0;
        id_rs1_used = 1; id_rs1_addr = 5'd0;
        #1 chk_eq("lu_x0_vec", 32'(w_vec), 32'(0));
        tick();

        // Redirect together with a load-use hazard
        ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; ex_redirect = 1;
        cnt_a = m_flush;
        #1 chk_eq("red_lu_vec", 32'(w_vec), 32'(V_RED));
        tick();
        chk_eq("red_flush_inc", 32'(flush_events_o), 32'(cnt_a + 1));
        set_idle(); tick();

        // Multi-cycle op: start at t0, done at t0+5
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            ex_mc_start = (i == 0);
            ex_mc_done  = (i == 5);
            #1;
            cnt_a += int'(pc_stall_o);
            cnt_b += int'(mc_busy_o);
            tick();
        end
        set_idle();
        chk_eq("mc_stall_cycles", 32'(cnt_a), 32'd5);
        chk_eq("mc_busy_cycles", 32'(cnt_b), 32'd5);
        tick();

        // Data-memory wait during MC_WAIT, done rising on the second held cycle
        ex_mc_start = 1; tick(); ex_mc_start = 0;
        for (int i = 0; i < 3; i++) begin
            mem_req_valid = 1; mem_ready = 0; ex_mc_done = (i >= 1);
            #1 chk_eq("mem_in_mc_vec", 32'(w_vec), 32'(V_MEM));
            tick();
            chk_eq("mem_in_mc_busy", 32'(mc_busy_o), 32'd1);
        end
        mem_ready = 1; tick();
        set_idle();
        chk_eq("mem_in_mc_release", 32'(mc_busy_o), 32'd0);
        tick();

        // Trap while waiting on both MC and memory
        ex_mc_start = 1; tick(); ex_mc_start = 0; tick();
        mem_req_valid = 1; mem_ready = 0; trap = 1;
        #1 chk_eq("trap_vec", 32'(w_vec), 32'(V_TRAP));
        tick(); set_idle();
        chk_eq("trap_busy", 32'(mc_busy_o), 32'd0);
        tick();

        // Watchdog: done never arrives
        ex_mc_start = 1; tick(); ex_mc_start = 0;
        cnt_a = 0;
        for (int i = 0; i < 10; i++) begin
            #1 cnt_a += int'(mc_timeout_o);
            tick();
        end
        chk_eq("timeout_pulses", 32'(cnt_a), 32'd1);
        ex_mc_done = 1; tick(); set_idle(); tick();

        // Reset in the middle of MC_WAIT
        ex_mc_start = 1; tick(); ex_mc_start = 0; tick(); tick();
        rst_n = 0; tick(); rst_n = 1; tick(); tick();

        // Counter saturation
        do_reset();
        ex_redirect = 1;
        for (int i = 0; i < CNT_MAX + 6; i++) tick();
        chk_eq("flush_sat", 32'(flush_events_o), 32'(CNT_MAX));
        set_idle(); mem_req_valid = 1;
        for (int i = 0; i < CNT_MAX + 6; i++) tick();
        chk_eq("stall_sat", 32'(stall_cycles_o), 32'(CNT_MAX));
        set_idle(); tick();

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            id_rs1_addr   = 5'($urandom_range(0, 3));
            id_rs2_addr   = 5'($urandom_range(0, 3));
            ex_rd_addr    = 5'($urandom_range(0, 3));
            id_rs1_used   = ($urandom_range(0, 1) == 1);
            id_rs2_used   = ($urandom_range(0, 1) == 1);
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_reg_write  = ($urandom_range(0, 1) == 1);
            ex_mc_start   = ($urandom_range(0, 7) == 0);
            ex_mc_done    = ($urandom_range(0, 3) == 0);
            ex_redirect   = ($urandom_range(0, 5) == 0);
            mem_req_valid = ($urandom_range(0, 2) == 0);
            mem_ready     = ($urandom_range(0, 1) == 1);
            trap          = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
